// File: rtl/sync_fifo_flags_if.sv
// rtl/sync_fifo_flags_if.sv - handshake, data and status bundle for sync_fifo_flags
interface sync_fifo_flags_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush;
  logic             clr_err;
  logic             w_en;
  logic [WIDTH-1:0] data_in;
  logic             full;
  logic             almost_full;
  logic             r_en;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, clr_err, w_en, data_in, r_en,
    input  full, almost_full, data_out, empty, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, w_en, data_in, r_en,
    output full, almost_full, data_out, empty, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - synchronous FIFO with flags; define SYNC_FIFO_FWFT_EN for first-word-fall-through
module sync_fifo_flags #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 1
) (
  input  logic                clk,
  input  logic                rstn,
  sync_fifo_flags_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          full;
  logic          empty;
  logic          wr_acc;
  logic          rd_acc;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  // Status decoded purely from registered pointers and count; the pointer MSB splits full from empty
  always_comb begin
    wr_idx = wr_ptr_q[AW-1:0];
    rd_idx = rd_ptr_q[AW-1:0];
    empty  = (wr_ptr_q == rd_ptr_q);
    full   = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    wr_acc = bus.w_en & ~full & ~bus.flush;
    rd_acc = bus.r_en & ~empty & ~bus.flush;
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = count_q;
  assign bus.almost_full  = (count_q >= PW'(AFULL_TH));
  assign bus.almost_empty = (count_q <= PW'(AEMPTY_TH));
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  // Next-state for pointers, occupancy and sticky errors; flush freezes the error flags
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + PW'(1);
        2'b01:   count_d = count_q - PW'(1);
        default: count_d = count_q;
      endcase
      overflow_d  = (overflow_q  & ~bus.clr_err) | (bus.w_en & full);
      underflow_d = (underflow_q & ~bus.clr_err) | (bus.r_en & empty);
    end
  end

  // Control state register with asynchronous clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array is never reset; discarding entries is done by clearing the pointers
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_idx] <= bus.data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry is presented directly whenever the FIFO holds data
  assign bus.data_out = empty ? '0 : mem[rd_idx];
`else
  logic [WIDTH-1:0] data_out_q, data_out_d;

  // Output register loads the head entry on an accepted read and holds otherwise
  always_comb begin
    data_out_d = data_out_q;
    if (bus.flush)   data_out_d = '0;
    else if (rd_acc) data_out_d = mem[rd_idx];
  end

  // Read data register with asynchronous clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) data_out_q <= '0;
    else       data_out_q <= data_out_d;
  end

  assign bus.data_out = data_out_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - directed self-checking bench for sync_fifo_flags
module tb_sync_fifo_flags;
  localparam int DEPTH = 8;
  localparam int WIDTH = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sync_fifo_flags_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) fif ();

  sync_fifo_flags #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .AFULL_TH(6), .AEMPTY_TH(1)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (fif.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input int cnt);
    check({tag, "_count"}, 32'(fif.count), 32'(cnt));
    check({tag, "_empty"}, 32'(fif.empty), 32'(cnt == 0));
    check({tag, "_full"}, 32'(fif.full), 32'(cnt == DEPTH));
    check({tag, "_aempty"}, 32'(fif.almost_empty), 32'(cnt <= 1));
    check({tag, "_afull"}, 32'(fif.almost_full), 32'(cnt >= 6));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    fif.flush   = 1'b0;
    fif.clr_err = 1'b0;
    fif.w_en    = 1'b0;
    fif.r_en    = 1'b0;
    fif.data_in = '0;
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    #3;
    check_status("reset", 0);
    check("reset_dout", 32'(fif.data_out), 32'h0);
    check("reset_ovf", 32'(fif.overflow), 32'h0);
    check("reset_unf", 32'(fif.underflow), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // fill 1..8, then one write too many
    for (int i = 1; i <= 8; i++) begin
      fif.w_en = 1'b1;
      fif.data_in = 16'(i);
      tick();
      check_status($sformatf("fill%0d", i), i);
    end
    fif.data_in = 16'h0009;
    tick();
    check("fill_ovf", 32'(fif.overflow), 32'h1);
    check_status("fill_over", 8);
    fif.w_en = 1'b0;

    // drain in order, then one read too many
    for (int i = 1; i <= 8; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      check($sformatf("drain_head%0d", i), 32'(fif.data_out), 32'(i));
`endif
      fif.r_en = 1'b1;
      tick();
`ifndef SYNC_FIFO_FWFT_EN
      check($sformatf("drain_data%0d", i), 32'(fif.data_out), 32'(i));
`endif
      check_status($sformatf("drain%0d", i), 8 - i);
    end
    tick();
    check("drain_unf", 32'(fif.underflow), 32'h1);
`ifdef SYNC_FIFO_FWFT_EN
    check("drain_hold", 32'(fif.data_out), 32'h0);
`else
    check("drain_hold", 32'(fif.data_out), 32'h8);
`endif
    check_status("drain_under", 0);
    fif.r_en = 1'b0;
    check("ovf_sticky", 32'(fif.overflow), 32'h1);

    // clear, then set-wins when clear and an error coincide
    fif.clr_err = 1'b1;
    tick();
    check("clr_ovf", 32'(fif.overflow), 32'h0);
    check("clr_unf", 32'(fif.underflow), 32'h0);
    fif.r_en = 1'b1;
    tick();
    check("setwins_unf", 32'(fif.underflow), 32'h1);
    fif.r_en = 1'b0;
    tick();
    check("clr2_unf", 32'(fif.underflow), 32'h0);
    fif.clr_err = 1'b0;

    // prime 3 entries then stream 20 simultaneous write/read cycles
    for (int j = 0; j < 3; j++) begin
      fif.w_en = 1'b1;
      fif.data_in = 16'(16'h0100 + j);
      tick();
    end
    check_status("wrap_prime", 3);
    fif.r_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      fif.data_in = 16'(16'h0103 + k);
`ifdef SYNC_FIFO_FWFT_EN
      check($sformatf("wrap_head%0d", k), 32'(fif.data_out), 32'(16'h0100 + k));
`endif
      tick();
`ifndef SYNC_FIFO_FWFT_EN
      check($sformatf("wrap_data%0d", k), 32'(fif.data_out), 32'(16'h0100 + k));
`endif
      check($sformatf("wrap_count%0d", k), 32'(fif.count), 32'd3);
    end
    check("wrap_ovf", 32'(fif.overflow), 32'h0);
    check("wrap_unf", 32'(fif.underflow), 32'h0);

    // boundary: drain to empty, w+r while empty, fill, w+r while full
    fif.w_en = 1'b0;
    repeat (3) tick();
    check_status("bnd_drained", 0);
    fif.w_en = 1'b1;
    fif.data_in = 16'h0300;
    tick();
    check_status("bnd_empty_wr", 1);
    check("bnd_empty_unf", 32'(fif.underflow), 32'h1);
    fif.r_en = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      fif.data_in = 16'(16'h0300 + j);
      tick();
    end
    check_status("bnd_full", 8);
    fif.r_en = 1'b1;
    fif.data_in = 16'h0308;
    tick();
    check_status("bnd_full_wr", 7);
    check("bnd_full_ovf", 32'(fif.overflow), 32'h1);
`ifdef SYNC_FIFO_FWFT_EN
    check("bnd_full_data", 32'(fif.data_out), 32'h0301);
`else
    check("bnd_full_data", 32'(fif.data_out), 32'h0300);
`endif
    fif.w_en = 1'b0;
    fif.r_en = 1'b0;
    fif.clr_err = 1'b1;
    tick();
    fif.clr_err = 1'b0;
    check("bnd_clr_ovf", 32'(fif.overflow), 32'h0);
    check("bnd_clr_unf", 32'(fif.underflow), 32'h0);
    check_status("bnd_clr", 7);

    // flush at count 5 with a concurrent write
    fif.r_en = 1'b1;
    repeat (2) tick();
    fif.r_en = 1'b0;
    check_status("fl_pre", 5);
    fif.flush = 1'b1;
    fif.w_en = 1'b1;
    fif.data_in = 16'hDEAD;
    tick();
    fif.flush = 1'b0;
    fif.w_en = 1'b0;
    check_status("fl_post", 0);
    check("fl_dout", 32'(fif.data_out), 32'h0);
    check("fl_ovf", 32'(fif.overflow), 32'h0);
    fif.r_en = 1'b1;
    tick();
    fif.r_en = 1'b0;
    check("fl_unf", 32'(fif.underflow), 32'h1);

    // refill to 5, pop one, then asynchronous reset between edges
    fif.w_en = 1'b1;
    for (int j = 0; j < 5; j++) begin
      fif.data_in = 16'(16'h0200 + j);
      tick();
    end
    fif.w_en = 1'b0;
    fif.r_en = 1'b1;
    tick();
    fif.r_en = 1'b0;
    check_status("rf_pre", 4);
`ifdef SYNC_FIFO_FWFT_EN
    check("rf_dout", 32'(fif.data_out), 32'h0201);
`else
    check("rf_dout", 32'(fif.data_out), 32'h0200);
`endif
    #2;
    rstn = 1'b0;
    #1;
    check_status("async_rst", 0);
    check("async_dout", 32'(fif.data_out), 32'h0);
    check("async_unf", 32'(fif.underflow), 32'h0);
    check("async_ovf", 32'(fif.overflow), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check_status("post_rst", 0);

    // single word through an empty FIFO
    fif.w_en = 1'b1;
    fif.data_in = 16'hABCD;
    tick();
    fif.w_en = 1'b0;
    check("one_empty", 32'(fif.empty), 32'h0);
`ifdef SYNC_FIFO_FWFT_EN
    check("one_dout", 32'(fif.data_out), 32'hABCD);
`else
    check("one_dout", 32'(fif.data_out), 32'h0);
`endif
    fif.r_en = 1'b1;
    tick();
    fif.r_en = 1'b0;
    check("one_rd_empty", 32'(fif.empty), 32'h1);
`ifdef SYNC_FIFO_FWFT_EN
    check("one_rd_dout", 32'(fif.data_out), 32'h0);
`else
    check("one_rd_dout", 32'(fif.data_out), 32'hABCD);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 Parameter DEPTH, default 8, number of entries; power of two, at least 2; all DEPTH entries usable.
REQ-002 Parameter WIDTH, default 16, data word width in bits.
REQ-003 Parameter AFULL_TH, default DEPTH-2, almost-full threshold in entries, range 1..DEPTH.
REQ-004 Parameter AEMPTY_TH, default 1, almost-empty threshold in entries, range 0..DEPTH-1.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rstn  input  1  reset; asynchronous assert, active-low.
REQ-007 flush  input  1  synchronous clear of FIFO contents.
REQ-008 w_en  input  1  write request.
REQ-009 data_in  input  WIDTH  write data.
REQ-010 full  output  1  FIFO holds DEPTH entries.
REQ-011 almost_full  output  1  count >= AFULL_TH.
REQ-012 r_en  input  1  read request (pop).
REQ-013 data_out  output  WIDTH  read data.
REQ-014 empty  output  1  FIFO holds 0 entries.
REQ-015 almost_empty  output  1  count <= AEMPTY_TH.
REQ-016 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-017 overflow  output  1  sticky: a write was attempted while full.
REQ-018 underflow  output  1  sticky: a read was attempted while empty.
REQ-019 clr_err  input  1  synchronous clear of overflow and underflow.

Function
REQ-020 The read and write pointers SHALL each be $clog2(DEPTH)+1 bits wide, with the extra MSB distinguishing full from empty.
REQ-021 A write SHALL be accepted iff w_en=1 and full=0; an accepted write stores data_in at the write pointer and increments the write pointer modulo 2*DEPTH.
REQ-022 A read SHALL be accepted iff r_en=1 and empty=0; an accepted read increments the read pointer modulo 2*DEPTH.
REQ-023 count SHALL change by +1 (write only), -1 (read only), or 0 (both or neither) on each edge.
REQ-024 Simultaneous w_en and r_en while empty: only the write is accepted, and underflow is set.
REQ-025 Simultaneous w_en and r_en while full: only the read is accepted, and overflow is set.
REQ-026 full, empty, almost_full, almost_empty and count SHALL be decoded from registered state only, with no combinational path from any input.
REQ-027 overflow SHALL set on w_en=1 with full=1; underflow SHALL set on r_en=1 with empty=1; both hold until clr_err=1 or reset.
REQ-028 If clr_err is asserted in the same cycle as a new error event, the flag SHALL be set (set wins).
REQ-029 flush=1 SHALL zero both pointers and count on that edge, ignore w_en/r_en in that cycle, leave memory contents and error flags unchanged, and set data_out to 0.
REQ-030 Pointers SHALL wrap seamlessly; ordering SHALL be strict first-in first-out across any number of wraps.

Reset
REQ-031 rstn=0 SHALL immediately, without waiting for clk, zero both pointers, count, data_out, overflow and underflow; empty=1, full=0, almost_empty=1, almost_full=0.
REQ-032 Memory contents SHALL NOT be reset; reset asserted mid-transfer SHALL discard all stored entries.

Configuration
REQ-033 Macro SYNC_FIFO_FWFT_EN defined: first-word-fall-through; data_out SHALL show the head entry in the same cycle empty=0; an accepted read advances it to the next entry at the edge; data_out=0 while empty.
REQ-034 SYNC_FIFO_FWFT_EN undefined: data_out SHALL be a register loaded with the head entry on the edge of an accepted read (1-cycle latency) and holding its value otherwise.

Verification
REQ-035 Fill: write 8 words 0x0001..0x0008, DEPTH=8 -> full=1 after 8th, count=8, almost_full=1 from count 6; a 9th write sets overflow=1 and count stays 8.
REQ-036 Drain: read 8 times after fill -> data 0x0001..0x0008 in order (non-FWFT: one cycle after each r_en), empty=1; a 9th read sets underflow=1 and data_out holds 0x0008.
REQ-037 Wrap: 20 cycles of simultaneous write/read at count=3 -> count stays 3, data matches FIFO order through 2+ pointer wraps, no error flags.
REQ-038 Boundary: w_en+r_en while empty -> count=1, underflow=1; w_en+r_en while full -> count=7, overflow=1; then clr_err -> both flags 0.
REQ-039 Flush/reset: count=5, flush with w_en=1 -> count=0, empty=1, data_out=0; refill to 4, drop rstn between edges -> outputs reach reset values before next clk edge.
REQ-040 FWFT build: single write 0xABCD to empty FIFO -> data_out=0xABCD on cycle after the write with empty=0, r_en -> empty=1, data_out=0.
